led_blink_ctrl: RTL and testbench

Command-driven controller that sequences an LED blinker output. A requester issues a blink command (half-period in clock cycles, number of blinks) over a valid/ready handshake. The block times the on/off phases, reports busy/done, and accepts an abort. It replaces the free-running fixed-rate blinker with a programmable, schedulable one in the LED/status path.

---
 rtl/led_blink_ctrl.sv | 116 +++++++++++
 tb/tb_led_blink_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: programmable LED blinker sequencer.
// A command (half-period H, blink count N) is accepted over valid/ready.
// The LED then runs N on/off periods of H cycles each. N=0 runs until
// stopped. busy covers the whole sequence. done pulses once when the
// sequence ends or is aborted.
module led_blink_ctrl #(
    parameter int CNT_W = 16,
    parameter int N_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_half,
    input  logic [N_W-1:0]   cmd_count,
    input  logic             cmd_stop,
    output logic             led,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] T_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [N_W-1:0]   N_ONE = {{(N_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] half_q;
    logic [N_W-1:0]   rem_q;
    logic             led_q;
    logic             busy_q;
    logic             done_q;

    // A half-period of 0 is treated as 1. All-ones H needs no extra width
    // because the timer only reloads to H-1 after it has reached 0.
    logic [CNT_W-1:0] half_d;
    assign half_d = (cmd_half == '0) ? T_ONE : cmd_half;

    assign cmd_ready = (state_q == S_IDLE);
    assign led       = led_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Sequencer FSM with registered led/busy/done. Stop takes priority over
    // timer expiry. done defaults low so that it is a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            half_q  <= T_ONE;
            rem_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        half_q  <= half_d;
                        rem_q   <= cmd_count;
                        timer_q <= half_d - T_ONE;
                        state_q <= S_ON;
                        led_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (cmd_stop) begin
                        state_q <= S_IDLE;
                        led_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (timer_q != '0) begin
                        timer_q <= timer_q - T_ONE;
                    end else begin
                        timer_q <= half_q - T_ONE;
                        state_q <= S_OFF;
                        led_q   <= 1'b0;
                    end
                end
                S_OFF: begin
                    if (cmd_stop) begin
                        state_q <= S_IDLE;
                        led_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (timer_q != '0) begin
                        timer_q <= timer_q - T_ONE;
                    end else if (rem_q == N_ONE) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        // rem_q == 0 means continuous mode and never counts down
                        state_q <= S_ON;
                        led_q   <= 1'b1;
                        timer_q <= half_q - T_ONE;
                        if (rem_q != '0) rem_q <= rem_q - N_ONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    led_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl. "Cycle k" means the interval that
// follows the k-th rising edge after the acceptance edge E. Outputs are
// sampled 1 time unit after each edge.
module tb_led_blink_ctrl;

    localparam int CNT_W = 16;
    localparam int N_W   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_half;
    logic [N_W-1:0]   cmd_count;
    logic             cmd_stop;
    logic             led;
    logic             busy;
    logic             done;

    int n_chk  = 0;
    int n_fail = 0;

    led_blink_ctrl #(.CNT_W(CNT_W), .N_W(N_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_half  (cmd_half),
        .cmd_count (cmd_count),
        .cmd_stop  (cmd_stop),
        .led       (led),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare led, busy, done and cmd_ready in one call
    task automatic chk4(input string tag, input logic l, input logic b, input logic d, input logic r);
        chk({tag, ".led"},   {31'd0, led},       {31'd0, l});
        chk({tag, ".busy"},  {31'd0, busy},      {31'd0, b});
        chk({tag, ".done"},  {31'd0, done},      {31'd0, d});
        chk({tag, ".ready"}, {31'd0, cmd_ready}, {31'd0, r});
    endtask

    // Present a command and let the acceptance edge pass; returns in cycle 1
    task automatic issue(input logic [CNT_W-1:0] h, input logic [N_W-1:0] n);
        cmd_half  = h;
        cmd_count = n;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Hand-computed expectations for H=3, N=2 (bit k = cycle k)
    logic [13:0] e_led  = 14'b00001110001110;
    logic [13:0] e_busy = 14'b01111111111110;
    logic [13:0] e_done = 14'b10000000000000;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_half = '0; cmd_count = '0; cmd_stop = 1'b0;
        #3;
        chk4("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        #9 rst = 1'b0;
        tick();
        chk4("idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // H=3, N=2 full waveform
        issue(16'd3, 8'd2);
        for (int k = 1; k <= 13; k++) begin
            chk4($sformatf("h3n2.c%0d", k), e_led[k], e_busy[k], e_done[k], ~e_busy[k]);
            tick();
        end
        chk4("h3n2.after", 1'b0, 1'b0, 1'b0, 1'b1);

        // H=0 acts as H=1
        issue(16'd0, 8'd1);
        chk4("h0.c1", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk4("h0.c2", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk4("h0.c3", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk4("h0.c4", 1'b0, 1'b0, 1'b0, 1'b1);

        // Continuous mode H=2: period 4, no done; then stop in ON
        issue(16'd2, 8'd0);
        for (int k = 1; k <= 40; k++) begin
            chk($sformatf("cont.led.c%0d", k), {31'd0, led}, {31'd0, ((k - 1) % 4) < 2});
            chk($sformatf("cont.done.c%0d", k), {31'd0, done}, 32'd0);
            tick();
        end
        chk4("cont.c41", 1'b1, 1'b1, 1'b0, 1'b0);
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        chk4("cont.stop", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk4("cont.stop+1", 1'b0, 1'b0, 1'b0, 1'b1);

        // Held valid with new fields during a sequence is ignored
        issue(16'd2, 8'd1);
        cmd_valid = 1'b1; cmd_half = 16'd5; cmd_count = 8'd3;
        chk4("hold.c1", 1'b1, 1'b1, 1'b0, 1'b0); tick();
        chk4("hold.c2", 1'b1, 1'b1, 1'b0, 1'b0); tick();
        chk4("hold.c3", 1'b0, 1'b1, 1'b0, 1'b0); tick();
        chk4("hold.c4", 1'b0, 1'b1, 1'b0, 1'b0); tick();
        chk4("hold.c5", 1'b0, 1'b0, 1'b1, 1'b1); tick();
        // The held command is accepted at the edge after done
        cmd_valid = 1'b0;
        for (int k = 6; k <= 10; k++) begin
            chk4($sformatf("hold.c%0d", k), 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk4("hold.c11", 1'b0, 1'b1, 1'b0, 1'b0);
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        chk4("hold.stop", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();

        // Stop coincident with final OFF expiry; stop in IDLE has no effect
        issue(16'd2, 8'd1);
        tick(); tick(); tick();
        chk4("lastoff.c4", 1'b0, 1'b1, 1'b0, 1'b0);
        cmd_stop = 1'b1;
        tick();
        chk4("lastoff.c5", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk4("lastoff.c6", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk4("idlestop", 1'b0, 1'b0, 1'b0, 1'b1);

        // Command together with stop in IDLE is accepted
        cmd_half = 16'd1; cmd_count = 8'd1; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0; cmd_stop = 1'b0;
        chk4("vstop.c1", 1'b1, 1'b1, 1'b0, 1'b0); tick();
        chk4("vstop.c2", 1'b0, 1'b1, 1'b0, 1'b0); tick();
        chk4("vstop.c3", 1'b0, 1'b0, 1'b1, 1'b1); tick();

        // Maximum half-period: led must stay high, then stop
        issue(16'hFFFF, 8'd1);
        for (int k = 1; k < 20; k++) tick();
        chk4("hmax.c20", 1'b1, 1'b1, 1'b0, 1'b0);
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        chk4("hmax.stop", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();

        // Asynchronous reset mid-ON, between edges
        issue(16'd4, 8'd1);
        tick();
        chk4("arst.pre", 1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk4("arst.now", 1'b0, 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b0;
        tick();
        chk4("arst.post", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
